seq_alu: RTL and testbench

Parametrised multi-cycle ALU that generalises the team's 1-bit ALU slice to a WIDTH-bit datapath. It adds registered results, a start/done handshake, status flags and a multi-cycle shift-add unsigned multiplier. It sits between the decode/control stage and writeback in the lab CPU datapath. Single-cycle ops complete in one clock; MUL takes WIDTH clocks.

---
 rtl/seq_alu.sv | 160 ++++++++++++++++
 tb/tb_seq_alu.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle WIDTH-bit ALU: registered single-cycle logic/arith ops plus a shift-add unsigned MUL.
// The multiplier exists only when SEQ_ALU_MUL_EN is defined; without it, op 1000 is reported as illegal.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic             illegal
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    logic [WIDTH:0]   add_sum, sub_sum;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] sc_res;
    logic             sc_cout, sc_ovf, sc_ill;
    logic             mul_start, mul_last, accept_sc;
    logic [WIDTH-1:0] mul_hi, mul_lo;

    always_comb begin
        add_sum = {1'b0, src1} + {1'b0, src2};
        sub_sum = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf = (src1[WIDTH-1] == src2[WIDTH-1])  && (add_sum[WIDTH-1] != src1[WIDTH-1]);
        sub_ovf = (src1[WIDTH-1] == ~src2[WIDTH-1]) && (sub_sum[WIDTH-1] != src1[WIDTH-1]);
    end

    // Anything not decoded here (including MUL, handled by the sequencer) falls out as illegal.
    always_comb begin
        sc_res  = '0;
        sc_cout = 1'b0;
        sc_ovf  = 1'b0;
        sc_ill  = 1'b0;
        case (op)
            OP_AND: sc_res = src1 & src2;
            OP_OR:  sc_res = src1 | src2;
            OP_NOR: sc_res = ~(src1 | src2);
            OP_ADD: begin
                sc_res  = add_sum[WIDTH-1:0];
                sc_cout = add_sum[WIDTH];
                sc_ovf  = add_ovf;
            end
            OP_SUB: begin
                sc_res  = sub_sum[WIDTH-1:0];
                sc_cout = sub_sum[WIDTH];
                sc_ovf  = sub_ovf;
            end
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_ovf};
            default: sc_ill = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] mcand, prod_hi, prod_lo;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   hi_add;

    // prod_lo starts as the multiplier and is consumed LSB-first as product bits shift in.
    always_comb begin
        hi_add           = prod_lo[0] ? ({1'b0, prod_hi} + {1'b0, mcand}) : {1'b0, prod_hi};
        {mul_hi, mul_lo} = {hi_add, prod_lo[WIDTH-1:1]};
    end

    assign busy      = (state == S_MUL);
    assign mul_start = start && (state == S_IDLE) && (op == OP_MUL);
    assign mul_last  = (state == S_MUL) && (count == CW'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (mul_start) state_nxt = S_MUL;
            S_MUL:  if (mul_last)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
            count   <= '0;
        end else if (mul_start) begin
            mcand   <= src1;
            prod_hi <= '0;
            prod_lo <= src2;
            count   <= CW'(WIDTH);
        end else if (state == S_MUL) begin
            prod_hi <= mul_hi;
            prod_lo <= mul_lo;
            count   <= count - CW'(1);
        end
    end
`else
    assign busy      = 1'b0;
    assign mul_start = 1'b0;
    assign mul_last  = 1'b0;
    assign mul_hi    = '0;
    assign mul_lo    = '0;
`endif

    assign accept_sc = start && !busy && !mul_start;

    // Final MUL iteration writes its combinational result straight into the output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_sc) begin
                result    <= sc_res;
                result_hi <= '0;
                zero      <= (sc_res == '0);
                cout      <= sc_cout;
                overflow  <= sc_ovf;
                illegal   <= sc_ill;
                done      <= 1'b1;
            end else if (mul_last) begin
                result    <= mul_lo;
                result_hi <= mul_hi;
                zero      <= ({mul_hi, mul_lo} == '0);
                cout      <= 1'b0;
                overflow  <= 1'b0;
                illegal   <= 1'b0;
                done      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu (WIDTH=32 against a behavioural model, plus a WIDTH=8 instance).
module tb_seq_alu;
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111, OP_NOR = 4'b1100, OP_MUL = 4'b1000;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [31:0] src1 = '0, src2 = '0;
    logic [31:0] result, result_hi;
    logic        zero, cout, overflow, busy, done, illegal;

    logic        s8_start = 1'b0;
    logic [3:0]  s8_op = 4'h0;
    logic [7:0]  s8_a = '0, s8_b = '0;
    logic [7:0]  r8, r8_hi;
    logic        z8, c8, v8, b8, d8, i8;

    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
        .result(result), .result_hi(result_hi), .zero(zero), .cout(cout),
        .overflow(overflow), .busy(busy), .done(done), .illegal(illegal)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .op(s8_op), .src1(s8_a), .src2(s8_b),
        .result(r8), .result_hi(r8_hi), .zero(z8), .cout(c8),
        .overflow(v8), .busy(b8), .done(d8), .illegal(i8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero, cout, ovf, ill;
    } mo_t;

    // Reference semantics from plain signed/unsigned arithmetic.
    function automatic mo_t eval(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        mo_t    r;
        longint sa, sb, ss;
        logic [63:0] u;
        r  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_AND: r.res = a & b;
            OP_OR:  r.res = a | b;
            OP_NOR: r.res = ~(a | b);
            OP_ADD: begin
                u      = {32'd0, a} + {32'd0, b};
                r.res  = u[31:0];
                r.cout = (u > 64'h0000_0000_FFFF_FFFF);
                ss     = sa + sb;
                r.ovf  = (ss > MAXS) || (ss < MINS);
            end
            OP_SUB: begin
                r.res  = a - b;
                r.cout = (a >= b);
                ss     = sa - sb;
                r.ovf  = (ss > MAXS) || (ss < MINS);
            end
            OP_SLT: r.res = (sa < sb) ? 32'd1 : 32'd0;
            OP_MUL: begin
                if (MUL_EN) begin
                    u     = {32'd0, a} * {32'd0, b};
                    r.res = u[31:0];
                    r.hi  = u[63:32];
                end else r.ill = 1'b1;
            end
            default: r.ill = 1'b1;
        endcase
        r.zero = (r.res == 32'd0) && (r.hi == 32'd0);
        return r;
    endfunction

    // Model: MUL is a countdown of WIDTH clocks before its product is published.
    mo_t  m_out, m_pend;
    logic m_done;
    int   m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out  <= '0;
            m_pend <= '0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_out  <= m_pend;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (MUL_EN && op == OP_MUL) begin
                    m_cnt  <= 32;
                    m_pend <= eval(op, src1, src2);
                end else begin
                    m_out  <= eval(op, src1, src2);
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy",      64'(busy),      64'(m_cnt > 0));
            chk("done",      64'(done),      64'(m_done));
            chk("result",    64'(result),    64'(m_out.res));
            chk("result_hi", 64'(result_hi), 64'(m_out.hi));
            chk("zero",      64'(zero),      64'(m_out.zero));
            chk("cout",      64'(cout),      64'(m_out.cout));
            chk("overflow",  64'(overflow),  64'(m_out.ovf));
            chk("illegal",   64'(illegal),   64'(m_out.ill));
        end
    end

    // Returns just after the accepting edge.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_op8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        s8_start = 1'b1; s8_op = o; s8_a = a; s8_b = b;
        @(posedge clk); #1;
        s8_start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int edges);
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!done) chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int edges, busy_cyc;
        logic [3:0] ops [10];
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL, 4'b0101, 4'b1111, 4'b0011};

        #1;
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'({zero, cout, overflow, busy, done, illegal}), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_res", 64'(result), 64'h8000_0000);
        chk("add_flags", 64'({done, busy, overflow, cout, zero}), 64'b10100);

        do_op(OP_SUB, 32'd5, 32'd5);
        chk("sub_res", 64'(result), 64'd0);
        chk("sub_flags", 64'({done, zero, cout, overflow}), 64'b1110);
        do_op(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("slt_res", 64'(result), 64'd1);
        chk("slt_done", 64'(done), 64'd1);

        do_op(4'b0101, 32'hDEAD_BEEF, 32'h1234_5678);
        chk("ill_flags", 64'({done, illegal, zero}), 64'b111);
        chk("ill_res", 64'({result_hi, result}), 64'd0);

`ifdef SEQ_ALU_MUL_EN
        do_op(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002);
        busy_cyc = busy ? 1 : 0;
        edges    = 0;
        while (!done && edges < 100) begin
            if (edges == 9) begin
                start = 1'b1; op = OP_ADD; src1 = 32'd1; src2 = 32'd1;
            end else start = 1'b0;
            @(posedge clk); #1;
            edges++;
            if (busy) busy_cyc++;
        end
        start = 1'b0;
        chk("mul_latency", 64'(edges), 64'd32);
        chk("mul_busy_cycles", 64'(busy_cyc), 64'd32);
        chk("mul_res", 64'({result_hi, result}), 64'h0000_0001_FFFF_FFFE);
        chk("mul_flags", 64'({zero, cout, overflow, illegal}), 64'd0);

        do_op(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
`else
        do_op(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("mul_off_flags", 64'({done, illegal, zero, busy}), 64'b1110);
        chk("mul_off_res", 64'({result_hi, result}), 64'd0);
        do_op(OP_OR, 32'h1234_5678, 32'h9ABC_DEF0);
`endif
        repeat (14) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_res", 64'({result_hi, result}), 64'd0);
        chk("async_rst_flags", 64'({zero, cout, overflow, busy, done, illegal}), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        do_op(OP_MUL, 32'd3, 32'd7);
`ifdef SEQ_ALU_MUL_EN
        wait_done("mul3x7", edges);
        chk("mul3x7", 64'({result_hi, result}), 64'd21);
`else
        chk("mul3x7_ill", 64'({illegal, zero}), 64'b11);
`endif

        do_op8(OP_AND, 8'hF0, 8'h3C);
        chk("w8_and", 64'(r8), 64'h30);
        do_op8(OP_OR, 8'hF0, 8'h3C);
        chk("w8_or", 64'(r8), 64'hFC);
        do_op8(OP_NOR, 8'hF0, 8'h3C);
        chk("w8_nor", 64'(r8), 64'h03);
        do_op8(OP_MUL, 8'hFF, 8'hFF);
`ifdef SEQ_ALU_MUL_EN
        edges = 0;
        while (!d8 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("w8_mul_latency", 64'(edges), 64'd8);
        chk("w8_mul", 64'({r8_hi, r8}), 64'hFE01);
`else
        chk("w8_mul_ill", 64'({d8, i8, r8}), 64'h300);
`endif

        for (int k = 0; k < 400; k++) begin
            start = ($urandom_range(0, 3) != 0);
            op    = ops[$urandom_range(0, 9)];
            src1  = rand_opnd();
            src2  = rand_opnd();
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
